// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg : shared constants, result type and saturating adder for the MAC array
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mac_pkg;

  // Widest accumulator the adder supports; callers sign-extend into this width.
  localparam int MAX_W       = 64;
  localparam int DEF_N       = 8;
  localparam int DEF_LANES   = 4;
  localparam int DEF_ACC_W   = 2 * DEF_N + 8;

  typedef struct packed {
    logic                    ovf;
    logic signed [MAX_W-1:0] sum;
  } sat_res_t;

  // Adds two values already sign-extended to MAX_W and limits the result to
  // 'width' bits, either clamping or wrapping; ovf flags an out-of-range sum.
  function automatic sat_res_t sat_add(input logic signed [MAX_W-1:0] a,
                                       input logic signed [MAX_W-1:0] b,
                                       input int                      width,
                                       input logic                    saturate);
    logic signed [MAX_W:0] s;
    logic signed [MAX_W:0] hi;
    logic signed [MAX_W:0] lo;
    logic signed [MAX_W:0] wr;
    sat_res_t              r;
    s  = $signed({a[MAX_W-1], a}) + $signed({b[MAX_W-1], b});
    hi = (65'sd1 <<< (width - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (width - 1));
    wr = (s <<< (MAX_W + 1 - width)) >>> (MAX_W + 1 - width);
    r.ovf = (s > hi) || (s < lo);
    if (!r.ovf)
      r.sum = s[MAX_W-1:0];
    else if (saturate)
      r.sum = (s > hi) ? hi[MAX_W-1:0] : lo[MAX_W-1:0];
    else
      r.sum = wr[MAX_W-1:0];
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mac_lane.sv
// ---------------------------------------------------------------------------
// mac_lane : one MAC lane - product register, accumulator, sticky overflow, result
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mac_lane
  import mac_pkg::*;
#(
  parameter int N        = 8,
  parameter int ACC_W    = 2 * N + 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    i_load,
  input  logic                    i_first,
  input  logic                    i_s2_fire,
  input  logic                    i_s1_first,
  input  logic                    i_s1_last,
  input  logic signed [N-1:0]     i_value,
  input  logic signed [N-1:0]     i_mult,
  input  logic signed [ACC_W-1:0] i_bias,
  output logic signed [ACC_W-1:0] o_mac,
  output logic                    o_ovf
);

  logic signed [2*N-1:0]   r_prod;
  logic signed [ACC_W-1:0] r_bias;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_mac;
  logic                    r_flag;
  logic                    r_ovf;

  logic signed [MAX_W-1:0] w_base;
  logic signed [MAX_W-1:0] w_addend;
  sat_res_t                w_res;
  logic                    w_flag;
  logic                    w_unused_hi;

  // A first beat seeds from the bias captured alongside its product.
  assign w_base      = i_s1_first ? {{(MAX_W-ACC_W){r_bias[ACC_W-1]}}, r_bias}
                                  : {{(MAX_W-ACC_W){r_acc[ACC_W-1]}}, r_acc};
  assign w_addend    = {{(MAX_W-2*N){r_prod[2*N-1]}}, r_prod};
  assign w_res       = sat_add(w_base, w_addend, ACC_W, SATURATE);
  assign w_flag      = w_res.ovf | (~i_s1_first & r_flag);
  assign w_unused_hi = ^w_res.sum[MAX_W-1:ACC_W];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_prod <= '0;
      r_bias <= '0;
      r_acc  <= '0;
      r_mac  <= '0;
      r_flag <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (i_load) begin
        r_prod <= i_value * i_mult;
        if (i_first) r_bias <= i_bias;
      end
      if (i_s2_fire) begin
        if (i_s1_last) begin
          r_mac  <= w_res.sum[ACC_W-1:0];
          r_ovf  <= w_flag;
          r_acc  <= '0;
          r_flag <= 1'b0;
        end else begin
          r_acc  <= w_res.sum[ACC_W-1:0];
          r_flag <= w_flag;
        end
      end
    end
  end

  assign o_mac = r_mac;
  assign o_ovf = r_ovf;

endmodule

`default_nettype wire

// File: rtl/mac_array_int.sv
// ---------------------------------------------------------------------------
// mac_array_int : LANES-wide signed MAC engine with valid/ready in and out
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mac_array_int
  import mac_pkg::*;
#(
  parameter int N        = 8,
  parameter int LANES    = 4,
  parameter int ACC_W    = 2 * N + 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic                     in_first_i,
  input  logic                     in_last_i,
  input  logic [LANES*N-1:0]       value_i,
  input  logic [LANES*N-1:0]       mult_i,
  input  logic [LANES*ACC_W-1:0]   bias_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [LANES*ACC_W-1:0]   mac_o,
  output logic [LANES-1:0]         overflow_o
);

  logic r_s1_valid;
  logic r_s1_first;
  logic r_s1_last;
  logic r_out_valid;

  logic w_stall;
  logic w_in_fire;
  logic w_s2_fire;

  // A held result freezes both stages; readiness never looks at in_valid_i.
  assign w_stall    = r_out_valid & ~out_ready_i;
  assign in_ready_o = ~w_stall;
  assign w_in_fire  = in_valid_i & ~w_stall;
  assign w_s2_fire  = r_s1_valid & ~w_stall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_valid  <= 1'b0;
      r_s1_first  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (!w_stall) begin
        r_s1_valid <= w_in_fire;
        r_s1_first <= in_first_i;
        r_s1_last  <= in_last_i;
      end
      if (w_s2_fire && r_s1_last)
        r_out_valid <= 1'b1;
      else if (out_ready_i)
        r_out_valid <= 1'b0;
    end
  end

  assign out_valid_o = r_out_valid;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mac_lane #(
      .N        (N),
      .ACC_W    (ACC_W),
      .SATURATE (SATURATE)
    ) u_lane (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .i_load     (w_in_fire),
      .i_first    (in_first_i),
      .i_s2_fire  (w_s2_fire),
      .i_s1_first (r_s1_first),
      .i_s1_last  (r_s1_last),
      .i_value    (value_i[l*N +: N]),
      .i_mult     (mult_i[l*N +: N]),
      .i_bias     (bias_i[l*ACC_W +: ACC_W]),
      .o_mac      (mac_o[l*ACC_W +: ACC_W]),
      .o_ovf      (overflow_o[l])
    );
  end

endmodule

`default_nettype wire
